// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, constants and helper functions
package aes_pkg;

    // Key-schedule controller states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_READY  = 2'd2,
        ST_SERVE  = 2'd3
    } ks_state_t;

    localparam int STORE_WORDS = 60;

    // Round constants 01..36, entry 0 in the most-significant byte
    localparam logic [79:0] RCON_TABLE = 80'h01_02_04_08_10_20_40_80_1b_36;

    // Forward S-box, entry 0 in the most-significant byte
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Byte x sits at bit offset 8*(255-x); 255-x is simply ~x
    function automatic logic [7:0] sbox(input logic [7:0] x);
        sbox = SBOX_TABLE[{~x, 3'b000} +: 8];
    endfunction

    // Rcon for round counter r (0-based); entry r sits at offset 8*(9-r)
    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [3:0] pos;
        pos  = 4'd9 - r;
        rcon = (r < 4'd10) ? RCON_TABLE[{pos, 3'b000} +: 8] : 8'h00;
    endfunction

    // Only the three standard key sizes are accepted
    function automatic logic pair_legal(input logic [3:0] nk, input logic [3:0] nr);
        pair_legal = ((nk == 4'd4) && (nr == 4'd10)) ||
                     ((nk == 4'd6) && (nr == 4'd12)) ||
                     ((nk == 4'd8) && (nr == 4'd14));
    endfunction

endpackage

// File: rtl/aes_subword.sv
// rtl/aes_subword.sv - four parallel S-box lookups on a 32-bit word
module aes_subword
    import aes_pkg::*;
(
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);

    assign o_word = {sbox(i_word[31:24]), sbox(i_word[23:16]),
                     sbox(i_word[15:8]),  sbox(i_word[7:0])};

endmodule

// File: rtl/inv_key_schedule.sv
// rtl/inv_key_schedule.sv - forward key expansion with reverse-order round-key delivery
module inv_key_schedule
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         KeyValid,
    input  logic [255:0] Key,
    input  logic [3:0]   Nk,
    input  logic [3:0]   Nr,
    input  logic         KeyNext,
    input  logic         DecFinish,
    output logic [127:0] RoundKey,
    output logic [3:0]   RoundIdx,
    output logic         KeyReady,
    output logic         SchedReady,
    output logic         Busy
);

    // Word 0 of Key and RoundKey is the most-significant 32 bits (FIPS byte order).

    ks_state_t      r_state;
    ks_state_t      w_state_next;

    logic [3:0]     r_nk;
    logic [3:0]     r_nr;
    logic [255:0]   r_key;
    logic [5:0]     r_idx;
    logic [2:0]     r_mod;
    logic [3:0]     r_rc;
    logic [3:0]     r_p;
    logic [1:0]     r_k;
    logic           r_fin;

    logic [127:0]   r_round_key;
    logic [3:0]     r_round_idx;
    logic           r_key_ready;
    logic           r_sched_ready;
    logic           r_busy;

    logic [31:0]    r_store [0:STORE_WORDS-1];

    logic           w_accept;
    logic           w_expand_we;
    logic           w_expand_done;
    logic           w_serve_start;
    logic           w_serve_done;
    logic           w_in_key;
    logic           w_mod_zero;
    logic           w_mod_last;
    logic           w_nk8_mid;
    logic [5:0]     w_last_idx;
    logic [5:0]     w_prev_idx;
    logic [5:0]     w_back_idx;
    logic [5:0]     w_serve_idx;
    logic [31:0]    w_prev;
    logic [31:0]    w_back;
    logic [31:0]    w_key_word;
    logic [31:0]    w_sub_in;
    logic [31:0]    w_sub_out;
    logic [31:0]    w_next_word;

    // Last word index is 4*(Nr+1)-1 = 4*Nr+3
    assign w_last_idx  = {r_nr, 2'b11};
    assign w_prev_idx  = r_idx - 6'd1;
    assign w_back_idx  = r_idx - {2'b00, r_nk};
    assign w_serve_idx = {r_p, r_k};

    assign w_in_key    = (r_idx < {2'b00, r_nk});
    assign w_mod_zero  = (r_mod == 3'd0);
    assign w_mod_last  = ({1'b0, r_mod} == (r_nk - 4'd1));
    assign w_nk8_mid   = (r_nk == 4'd8) && (r_mod == 3'd4);

    assign w_prev      = r_store[w_prev_idx];
    assign w_back      = r_store[w_back_idx];
    assign w_key_word  = r_key[{~r_idx[2:0], 5'b00000} +: 32];

    // RotWord only on the i mod Nk = 0 path; the Nk=8 mid path uses the word as-is
    assign w_sub_in    = w_mod_zero ? {w_prev[23:0], w_prev[31:24]} : w_prev;

    aes_subword u_subword (
        .i_word (w_sub_in),
        .o_word (w_sub_out)
    );

    // Next schedule word for index r_idx
    always_comb begin
        w_next_word = w_back ^ w_prev;
        if (w_in_key) begin
            w_next_word = w_key_word;
        end else if (w_mod_zero) begin
            w_next_word = w_back ^ w_sub_out ^ {rcon(r_rc), 24'h000000};
        end else if (w_nk8_mid) begin
            w_next_word = w_back ^ w_sub_out;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and control strobes
    always_comb begin
        w_state_next  = r_state;
        w_accept      = 1'b0;
        w_expand_done = 1'b0;
        w_serve_start = 1'b0;
        w_serve_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (KeyValid && pair_legal(Nk, Nr)) begin
                    w_state_next = ST_EXPAND;
                    w_accept     = 1'b1;
                end
            end
            ST_EXPAND: begin
                if (r_idx == w_last_idx) begin
                    w_state_next  = ST_READY;
                    w_expand_done = 1'b1;
                end
            end
            ST_READY: begin
                if (KeyValid && pair_legal(Nk, Nr)) begin
                    w_state_next = ST_EXPAND;
                    w_accept     = 1'b1;
                end else if (KeyNext) begin
                    w_state_next  = ST_SERVE;
                    w_serve_start = 1'b1;
                end
            end
            ST_SERVE: begin
                if (r_k == 2'd3) begin
                    w_state_next = ST_READY;
                    w_serve_done = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_expand_we = (r_state == ST_EXPAND);

    // Word store: single write port, no reset (contents are rebuilt on every load)
    always_ff @(posedge clk) begin
        if (w_expand_we) begin
            r_store[r_idx] <= w_next_word;
        end
    end

    // Expansion counters, delivery pointer and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_nk          <= 4'd0;
            r_nr          <= 4'd0;
            r_key         <= '0;
            r_idx         <= 6'd0;
            r_mod         <= 3'd0;
            r_rc          <= 4'd0;
            r_p           <= 4'd0;
            r_k           <= 2'd0;
            r_fin         <= 1'b0;
            r_round_key   <= '0;
            r_round_idx   <= 4'd0;
            r_key_ready   <= 1'b0;
            r_sched_ready <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_key_ready <= 1'b0;
            r_busy      <= (w_state_next == ST_EXPAND) || (w_state_next == ST_SERVE);

            if (w_accept) begin
                r_nk          <= Nk;
                r_nr          <= Nr;
                r_key         <= Key;
                r_idx         <= 6'd0;
                r_mod         <= 3'd0;
                r_rc          <= 4'd0;
                r_sched_ready <= 1'b0;
            end

            if (w_expand_we) begin
                r_idx <= r_idx + 6'd1;
                r_mod <= w_mod_last ? 3'd0 : r_mod + 3'd1;
                if (w_mod_zero && !w_in_key) begin
                    r_rc <= r_rc + 4'd1;
                end
                if (w_expand_done) begin
                    r_sched_ready <= 1'b1;
                    r_p           <= r_nr;
                end
            end

            // A rewind in READY lands before a same-cycle request is served
            if (r_state == ST_READY && DecFinish) begin
                r_p <= r_nr;
            end

            if (w_serve_start) begin
                r_k   <= 2'd0;
                r_fin <= 1'b0;
            end

            if (r_state == ST_SERVE) begin
                r_round_key[{~r_k, 5'b00000} +: 32] <= r_store[w_serve_idx];
                r_k <= r_k + 2'd1;
                if (DecFinish) begin
                    r_fin <= 1'b1;
                end
                if (w_serve_done) begin
                    r_key_ready <= 1'b1;
                    r_round_idx <= r_p;
                    if (r_fin || DecFinish) begin
                        r_p <= r_nr;
                    end else begin
                        r_p <= (r_p == 4'd0) ? r_nr : r_p - 4'd1;
                    end
                end
            end
        end
    end

    assign RoundKey   = r_round_key;
    assign RoundIdx   = r_round_idx;
    assign KeyReady   = r_key_ready;
    assign SchedReady = r_sched_ready;
    assign Busy       = r_busy;

endmodule

// File: tb/tb_inv_key_schedule.sv
// tb/tb_inv_key_schedule.sv - self-checking bench for inv_key_schedule
module tb_inv_key_schedule;

    logic         clk = 1'b0;
    logic         rst;
    logic         KeyValid;
    logic [255:0] Key;
    logic [3:0]   Nk;
    logic [3:0]   Nr;
    logic         KeyNext;
    logic         DecFinish;
    logic [127:0] RoundKey;
    logic [3:0]   RoundIdx;
    logic         KeyReady;
    logic         SchedReady;
    logic         Busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    inv_key_schedule dut (
        .clk        (clk),
        .rst        (rst),
        .KeyValid   (KeyValid),
        .Key        (Key),
        .Nk         (Nk),
        .Nr         (Nr),
        .KeyNext    (KeyNext),
        .DecFinish  (DecFinish),
        .RoundKey   (RoundKey),
        .RoundIdx   (RoundIdx),
        .KeyReady   (KeyReady),
        .SchedReady (SchedReady),
        .Busy       (Busy)
    );

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] key;
        bit           chk_key;
    } exp_t;

    typedef struct {
        logic [3:0]   nk;
        logic [3:0]   nr;
        logic [255:0] key;
        logic [127:0] k_nr;
        logic [127:0] k_1;
        int           sched;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic load(input logic [3:0] nk, input logic [3:0] nr, input logic [255:0] key,
                        output int cyc);
        Nk = nk;
        Nr = nr;
        Key = key;
        KeyValid = 1'b1;
        tick();
        KeyValid = 1'b0;
        cyc = 1;
        check("sched_drop", 128'(SchedReady), 128'd0);
        while (!SchedReady && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    task automatic request(input int idx, input logic [127:0] key, input bit chk, input bit fin);
        exp_t e;
        int n;
        e.idx = 4'(idx);
        e.key = key;
        e.chk_key = chk;
        exp_q.push_back(e);
        KeyNext = 1'b1;
        DecFinish = fin;
        tick();
        KeyNext = 1'b0;
        DecFinish = 1'b0;
        n = 1;
        while (!KeyReady && n < 20) begin
            tick();
            n++;
        end
        check("latency", 128'(n), 128'd5);
        e = exp_q.pop_front();
        if (KeyReady) begin
            check("round_idx", 128'(RoundIdx), 128'(e.idx));
            if (e.chk_key) check("round_key", RoundKey, e.key);
        end
        tick();
        check("pulse_width", 128'(KeyReady), 128'd0);
    endtask

    task automatic count_ready(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (KeyReady) cnt++;
        end
    endtask

    localparam logic [255:0] KEY_A1  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY_128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};

    initial begin
        int cyc;
        int cnt;
        logic [127:0] kexp;

        vecs[0] = '{4'd4, 4'd10, KEY_A1,
                    128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
                    128'ha0fafe1788542cb123a339392a6c7605, 45};
        vecs[1] = '{4'd4, 4'd10, KEY_128,
                    128'h13111d7fe3944a17f307a78b4d2b30c5,
                    128'hd6aa74fdd2af72fadaa678f1d6ab76fe, 45};
        vecs[2] = '{4'd6, 4'd12, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
                    128'ha4970a331a78dc09c418c271e3a41d5d,
                    128'h10111213141516175846f2f95c43f4fe, 53};
        vecs[3] = '{4'd8, 4'd14, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                    128'h24fc79ccbf0979e9371ac23c6d68de36,
                    128'h101112131415161718191a1b1c1d1e1f, 61};

        rst = 1'b0;
        KeyValid = 1'b0;
        Key = '0;
        Nk = 4'd0;
        Nr = 4'd0;
        KeyNext = 1'b0;
        DecFinish = 1'b0;
        tick();
        tick();
        check("rst_roundkey", RoundKey, 128'd0);
        check("rst_roundidx", 128'(RoundIdx), 128'd0);
        check("rst_keyready", 128'(KeyReady), 128'd0);
        check("rst_schedready", 128'(SchedReady), 128'd0);
        check("rst_busy", 128'(Busy), 128'd0);
        rst = 1'b1;
        tick();

        // Full reverse schedule for each key size, plus the wrap to round Nr
        foreach (vecs[v]) begin
            load(vecs[v].nk, vecs[v].nr, vecs[v].key, cyc);
            check("sched_cycles", 128'(cyc), 128'(vecs[v].sched));
            for (int r = int'(vecs[v].nr); r >= 0; r--) begin
                kexp = (r == int'(vecs[v].nr)) ? vecs[v].k_nr :
                       (r == 1) ? vecs[v].k_1 :
                       (r == 0) ? vecs[v].key[255:128] : 128'd0;
                request(r, kexp, (r == int'(vecs[v].nr)) || (r <= 1), 1'b0);
            end
            request(int'(vecs[v].nr), vecs[v].k_nr, 1'b1, 1'b0);
        end

        // Rewind after three deliveries
        load(4'd4, 4'd10, KEY_128, cyc);
        request(10, vecs[1].k_nr, 1'b1, 1'b0);
        request(9, 128'd0, 1'b0, 1'b0);
        request(8, 128'd0, 1'b0, 1'b0);
        DecFinish = 1'b1;
        tick();
        DecFinish = 1'b0;
        request(10, vecs[1].k_nr, 1'b1, 1'b0);
        request(9, 128'd0, 1'b0, 1'b0);
        // DecFinish and KeyNext together: rewind first, then serve round Nr
        request(10, vecs[1].k_nr, 1'b1, 1'b1);

        // DecFinish and a stray KeyNext during SERVE
        KeyNext = 1'b1;
        tick();
        KeyNext = 1'b0;
        tick();
        DecFinish = 1'b1;
        KeyNext = 1'b1;
        tick();
        DecFinish = 1'b0;
        KeyNext = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (KeyReady) begin
                cnt++;
                check("serve_fin_idx", 128'(RoundIdx), 128'd9);
            end
            tick();
        end
        check("serve_fin_count", 128'(cnt), 128'd1);
        request(10, vecs[1].k_nr, 1'b1, 1'b0);

        // KeyValid during EXPAND is ignored
        Nk = 4'd4;
        Nr = 4'd10;
        Key = KEY_A1;
        KeyValid = 1'b1;
        tick();
        KeyValid = 1'b0;
        check("reload_drop", 128'(SchedReady), 128'd0);
        cyc = 1;
        while (!SchedReady && cyc < 200) begin
            KeyValid = (cyc == 10);
            Key = (cyc == 10) ? KEY_128 : KEY_A1;
            tick();
            cyc++;
        end
        KeyValid = 1'b0;
        check("expand_kv_cycles", 128'(cyc), 128'd45);
        request(10, vecs[0].k_nr, 1'b1, 1'b0);

        // Reset in the middle of EXPAND
        Nk = 4'd8;
        Nr = 4'd14;
        Key = vecs[3].key;
        KeyValid = 1'b1;
        tick();
        KeyValid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("expand_busy", 128'(Busy), 128'd1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_busy", 128'(Busy), 128'd0);
        check("mid_rst_sched", 128'(SchedReady), 128'd0);
        check("mid_rst_roundkey", RoundKey, 128'd0);
        check("mid_rst_roundidx", 128'(RoundIdx), 128'd0);
        check("mid_rst_keyready", 128'(KeyReady), 128'd0);
        tick();
        rst = 1'b1;
        tick();
        KeyNext = 1'b1;
        tick();
        KeyNext = 1'b0;
        count_ready(8, cnt);
        check("idle_keynext", 128'(cnt), 128'd0);
        check("idle_busy", 128'(Busy), 128'd0);

        // Illegal key size stays in IDLE
        Nk = 4'd5;
        Nr = 4'd10;
        KeyValid = 1'b1;
        tick();
        KeyValid = 1'b0;
        check("nk5_busy", 128'(Busy), 128'd0);
        for (int i = 0; i < 50; i++) tick();
        check("nk5_sched", 128'(SchedReady), 128'd0);
        check("nk5_busy_late", 128'(Busy), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
